// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package data_mem_arb_pkg;

  // Last owner granted; doubles as the owner of the response due this cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_DBG  = 2'd2
  } arb_state_e;

  // On-chip data window 0x800-0xFFF: masked address must equal the base.
  localparam logic [63:0] WIN_BASE = 64'h0000_0000_0000_0800;
  localparam logic [63:0] WIN_MASK = 64'hFFFF_FFFF_FFFF_F800;

endpackage

// File: rtl/dmem_addr_decode.sv
// Decodes whether a byte address falls inside the on-chip data window.
module dmem_addr_decode
  import data_mem_arb_pkg::*;
(
  input  logic [63:0] addr,
  output logic        hit
);

  assign hit = ((addr & WIN_MASK) == WIN_BASE);

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the core and debug ports onto the on-chip data memory.
// Core has priority; debug is guaranteed a grant after MAX_HOLD consecutive
// core grants while it waits. CNT_W must satisfy 2^CNT_W > MAX_HOLD.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        core_req,
  input  logic [63:0] core_addr,
  input  logic [63:0] core_wdata,
  input  logic        core_we,
  input  logic [2:0]  core_func3,
  output logic        core_ready,
  output logic        core_rvalid,
  output logic [63:0] core_rdata,
  output logic        core_err,
  input  logic        dbg_req,
  input  logic [63:0] dbg_addr,
  input  logic [63:0] dbg_wdata,
  input  logic        dbg_we,
  input  logic [2:0]  dbg_func3,
  output logic        dbg_ready,
  output logic        dbg_rvalid,
  output logic [63:0] dbg_rdata,
  output logic        dbg_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic [63:0] mem_rdata
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             resp_miss_q, resp_miss_d;
  logic             resp_rd_q, resp_rd_d;

  logic             core_gnt, dbg_gnt, any_gnt, win_hit;
  logic [63:0]      gnt_addr, gnt_wdata;
  logic             gnt_we;
  logic [2:0]       gnt_func3;

  // Grant selection, granted-request mux, next owner and hold counter.
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    core_gnt  = 1'b0;
    dbg_gnt   = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    gnt_we    = 1'b0;
    gnt_func3 = '0;
    state_d   = ST_IDLE;
    hold_d    = hold_q;

    if (core_req && !(dbg_req && (hold_q == HOLD_MAX))) begin
      core_gnt = 1'b1;
    end else if (dbg_req) begin
      dbg_gnt = 1'b1;
    end

    if (core_gnt) begin
      gnt_addr  = core_addr;
      gnt_wdata = core_wdata;
      gnt_we    = core_we;
      gnt_func3 = core_func3;
      state_d   = ST_CORE;
    end else if (dbg_gnt) begin
      gnt_addr  = dbg_addr;
      gnt_wdata = dbg_wdata;
      gnt_we    = dbg_we;
      gnt_func3 = dbg_func3;
      state_d   = ST_DBG;
    end

    if (!dbg_req || dbg_gnt) begin
      hold_d = '0;
    end else if (core_gnt && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + CNT_W'(1);
    end
  end

  assign any_gnt    = core_gnt | dbg_gnt;
  assign core_ready = core_gnt;
  assign dbg_ready  = dbg_gnt;

  dmem_addr_decode u_decode (
    .addr (gnt_addr),
    .hit  (win_hit)
  );

  // Drive the memory only for an accepted window hit; record what the
  // response next cycle must look like.
  always_comb begin
    mem_en      = any_gnt & win_hit;
    mem_we      = mem_en & gnt_we;
    mem_addr    = mem_en ? gnt_addr[10:0] : 11'd0;
    mem_wdata   = mem_en ? gnt_wdata : 64'd0;
    mem_func3   = mem_en ? gnt_func3 : 3'd0;
    resp_miss_d = any_gnt & ~win_hit;
    resp_rd_d   = mem_en & ~gnt_we;
  end

  // Steer the one-cycle-late response to the registered owner only.
  always_comb begin
    core_rvalid = 1'b0;
    core_rdata  = '0;
    core_err    = 1'b0;
    dbg_rvalid  = 1'b0;
    dbg_rdata   = '0;
    dbg_err     = 1'b0;
    case (state_q)
      ST_CORE: begin
        core_rvalid = 1'b1;
        core_rdata  = resp_rd_q ? mem_rdata : 64'd0;
        core_err    = resp_miss_q;
      end
      ST_DBG: begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = resp_rd_q ? mem_rdata : 64'd0;
        dbg_err    = resp_miss_q;
      end
      default: ;
    endcase
  end

  // Owner, hold counter and response attributes; reset drops any pending
  // response.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      resp_miss_q <= 1'b0;
      resp_rd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      resp_miss_q <= resp_miss_d;
      resp_rd_q   <= resp_rd_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized self-checking bench for data_mem_arbiter with a transaction-level
// reference model of arbitration, window decode and response timing.
module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        core_req, core_we, core_ready, core_rvalid, core_err;
  logic [63:0] core_addr, core_wdata, core_rdata;
  logic [2:0]  core_func3;
  logic        dbg_req, dbg_we, dbg_ready, dbg_rvalid, dbg_err;
  logic [63:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [2:0]  dbg_func3;
  logic        mem_en, mem_we;
  logic [10:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;

  int checks = 0;
  int errors = 0;

  // Reference model: consecutive core wins while debug waits, and the one
  // response owed next cycle (0 none, 1 core, 2 debug).
  int m_hold;
  int m_pend;
  bit m_pend_rd;
  bit m_pend_miss;

  always #5 clk = ~clk;

  data_mem_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .core_req(core_req), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_we(core_we), .core_func3(core_func3), .core_ready(core_ready),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_we(dbg_we), .dbg_func3(dbg_func3), .dbg_ready(dbg_ready),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [63:0] a);
    return (a >= 64'h800) && (a <= 64'hFFF);
  endfunction

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'h7FF;
      2: return 64'h800;
      3: return 64'hFFF;
      4: return 64'h1000;
      5: return 64'h800 + 64'($urandom_range(0, 2047));
      6: return {32'h0, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic idle_inputs();
    core_req = 0; core_addr = 0; core_wdata = 0; core_we = 0; core_func3 = 0;
    dbg_req = 0;  dbg_addr = 0;  dbg_wdata = 0;  dbg_we = 0;  dbg_func3 = 0;
    mem_rdata = 0;
  endtask

  task automatic model_clear();
    m_hold = 0; m_pend = 0; m_pend_rd = 0; m_pend_miss = 0;
  endtask

  // Called after inputs were set at the falling edge: checks every output
  // against the model, then advances the model to the next rising edge.
  task automatic eval();
    bit          e_cg, e_dg, e_hit, e_we;
    logic [63:0] e_addr, e_wd;
    logic [2:0]  e_f3;
    logic [10:0] e_off;
    #1;
    e_cg = core_req && !(dbg_req && (m_hold == MAX_HOLD));
    e_dg = dbg_req && !e_cg;
    e_addr = e_cg ? core_addr  : dbg_addr;
    e_wd   = e_cg ? core_wdata : dbg_wdata;
    e_we   = e_cg ? core_we    : dbg_we;
    e_f3   = e_cg ? core_func3 : dbg_func3;
    e_hit  = (e_cg || e_dg) && in_window(e_addr);
    e_off  = e_addr[10:0];
    check("core_ready", 64'(core_ready), 64'(e_cg));
    check("dbg_ready",  64'(dbg_ready),  64'(e_dg));
    check("mem_en",     64'(mem_en),     64'(e_hit));
    check("mem_we",     64'(mem_we),     64'(e_hit && e_we));
    check("mem_addr",   64'(mem_addr),   e_hit ? 64'(e_off) : 64'd0);
    check("mem_wdata",  mem_wdata,       e_hit ? e_wd : 64'd0);
    check("mem_func3",  64'(mem_func3),  e_hit ? 64'(e_f3) : 64'd0);
    check("core_rvalid", 64'(core_rvalid), 64'(m_pend == 1));
    check("core_rdata",  core_rdata, (m_pend == 1 && m_pend_rd) ? mem_rdata : 64'd0);
    check("core_err",    64'(core_err),  64'(m_pend == 1 && m_pend_miss));
    check("dbg_rvalid",  64'(dbg_rvalid), 64'(m_pend == 2));
    check("dbg_rdata",   dbg_rdata, (m_pend == 2 && m_pend_rd) ? mem_rdata : 64'd0);
    check("dbg_err",     64'(dbg_err),   64'(m_pend == 2 && m_pend_miss));
    m_pend      = e_cg ? 1 : (e_dg ? 2 : 0);
    m_pend_rd   = e_hit && !e_we;
    m_pend_miss = (e_cg || e_dg) && !in_window(e_addr);
    if (!dbg_req || e_dg) m_hold = 0;
    else if (e_cg && m_hold < MAX_HOLD) m_hold++;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_core_rvalid"}, 64'(core_rvalid), 64'd0);
    check({tag, "_dbg_rvalid"},  64'(dbg_rvalid),  64'd0);
    check({tag, "_core_err"},    64'(core_err),    64'd0);
    check({tag, "_dbg_err"},     64'(dbg_err),     64'd0);
    check({tag, "_mem_en"},      64'(mem_en),      64'd0);
    check({tag, "_mem_addr"},    64'(mem_addr),    64'd0);
    check({tag, "_state"},       64'(dut.state_q), 64'(ST_IDLE));
  endtask

  initial begin
    idle_inputs();
    model_clear();
    resetn = 0;
    repeat (2) @(negedge clk);
    #1 check_quiet("reset");
    resetn = 1;

    // Core read 0x808 alone, then its response with the given memory data.
    @(negedge clk); core_req = 1; core_addr = 64'h808; core_we = 0; core_func3 = 3'd3;
    eval();
    check("d039_ready", 64'(core_ready), 64'd1);
    @(negedge clk); idle_inputs(); mem_rdata = 64'h1122334455667788;
    eval();
    check("d039_rdata", core_rdata, 64'h1122334455667788);
    check("d039_err",   64'(core_err), 64'd0);

    // Debug write outside the window.
    @(negedge clk); idle_inputs(); dbg_req = 1; dbg_addr = 64'h1000; dbg_we = 1;
    dbg_wdata = 64'hDEAD_BEEF;
    eval();
    check("d041_mem_en", 64'(mem_en), 64'd0);
    @(negedge clk); idle_inputs(); mem_rdata = 64'hFFFF_0000_FFFF_0000;
    eval();
    check("d041_err",   64'(dbg_err),   64'd1);
    check("d041_rdata", dbg_rdata,      64'd0);

    // Core write 0x800 then debug read 0x800 back to back.
    @(negedge clk); idle_inputs(); core_req = 1; core_addr = 64'h800; core_we = 1;
    core_wdata = 64'hA5A5_5A5A_0102_0304; core_func3 = 3'd3;
    eval();
    check("d042_we", 64'(mem_we), 64'd1);
    @(negedge clk); idle_inputs(); dbg_req = 1; dbg_addr = 64'h800; mem_rdata = 64'h77;
    eval();
    check("d042_core_rvalid", 64'(core_rvalid), 64'd1);
    check("d042_rd_en", 64'({mem_en, mem_we}), 64'b10);
    @(negedge clk); idle_inputs(); mem_rdata = 64'hA5A5_5A5A_0102_0304;
    eval();
    check("d042_dbg_rvalid", 64'(dbg_rvalid), 64'd1);
    check("d042_dbg_rdata",  dbg_rdata, 64'hA5A5_5A5A_0102_0304);

    // Window edges.
    @(negedge clk); idle_inputs(); core_req = 1; core_addr = 64'hFFF;
    eval();
    check("d044_fff_addr", 64'(mem_addr), 64'h7FF);
    @(negedge clk); core_addr = 64'h7FF; eval();
    check("d044_7ff_en", 64'(mem_en), 64'd0);
    @(negedge clk); core_addr = 64'h0; eval();
    check("d044_0_err_prev", 64'(core_err), 64'd1);
    @(negedge clk); idle_inputs(); eval();

    // Continuous contention: 8 core grants then 1 debug grant, repeating.
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      core_req = 1; core_addr = 64'h900; dbg_req = 1; dbg_addr = 64'hA00;
      mem_rdata = {$urandom(), $urandom()};
      eval();
      check("d040_dbg_slot", 64'(dbg_ready), 64'((i % 9) == 8));
    end
    @(negedge clk); idle_inputs(); eval();

    // Reset the cycle after an accept: the pending response is dropped.
    @(negedge clk); core_req = 1; core_addr = 64'h808; eval();
    @(negedge clk); idle_inputs(); resetn = 0;
    #1 check_quiet("d043");
    @(negedge clk); resetn = 1; model_clear();
    eval();
    check("d043_no_rvalid", 64'(core_rvalid), 64'd0);

    // Randomized traffic with sticky debug request to exercise the hold limit.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      core_req   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dbg_req = ~dbg_req;
      core_addr  = pick_addr();
      core_wdata = {$urandom(), $urandom()};
      core_we    = $urandom_range(0, 1);
      core_func3 = 3'($urandom_range(0, 7));
      dbg_addr   = pick_addr();
      dbg_wdata  = {$urandom(), $urandom()};
      dbg_we     = $urandom_range(0, 1);
      dbg_func3  = 3'($urandom_range(0, 7));
      mem_rdata  = {$urandom(), $urandom()};
      eval();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8: max consecutive core grants while debug waits.
REQ-002 SHALL have parameter CNT_W, default 4: width of hold counter; SHALL satisfy 2^CNT_W > MAX_HOLD.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 resetn  in  1  reset, asynchronous and active-low.
REQ-005 core_req  in  1  core memory-stage request.
REQ-006 core_addr  in  64  core byte address.
REQ-007 core_wdata  in  64  core store data.
REQ-008 core_we  in  1  core write (1) / read (0).
REQ-009 core_func3  in  3  core size/signedness, passed to memory.
REQ-010 core_ready  out  1  core request accepted this cycle (grant).
REQ-011 core_rvalid  out  1  core response valid.
REQ-012 core_rdata  out  64  core response data.
REQ-013 core_err  out  1  core response is an address fault.
REQ-014 dbg_req, dbg_addr[64], dbg_wdata[64], dbg_we, dbg_func3[3] in; dbg_ready, dbg_rvalid, dbg_rdata[64], dbg_err out: debug/loader port, same meaning as core.
REQ-015 mem_en  out  1  on-chip data memory access this cycle.
REQ-016 mem_we  out  1  on-chip memory write enable.
REQ-017 mem_addr  out  11  on-chip word/byte offset (address bits 10:0).
REQ-018 mem_wdata  out  64  store data; mem_func3  out  3  size/signedness.
REQ-019 mem_rdata  in  64  memory read data, valid one cycle after mem_en.

Function
REQ-020 Request SHALL be accepted in the cycle where req and ready are both high; ready SHALL be combinational from req inputs and registered state.
REQ-021 Only one requester SHALL be granted per cycle; throughput one accepted request per cycle.
REQ-022 FSM states IDLE, CORE, DBG record last owner; next state = owner granted this cycle, IDLE if none.
REQ-023 Only one requesting: that requester SHALL be granted.
REQ-024 Both requesting: core SHALL be granted unless hold counter equals MAX_HOLD, then debug SHALL be granted.
REQ-025 Hold counter SHALL increment on each core grant while dbg_req high, saturate at MAX_HOLD, clear on any debug grant or any cycle dbg_req is low.
REQ-026 Window hit SHALL be addr[63:12]==0 and addr[11]==1 (0x800-0xFFF).
REQ-027 Accepted hit: mem_en=1, mem_we=we, mem_addr=addr[10:0], wdata/func3 forwarded same cycle.
REQ-028 Accepted miss: mem_en=0, mem_we=0; access SHALL NOT reach memory.
REQ-029 rvalid of the accepting port SHALL assert exactly one cycle after acceptance, for reads and writes.
REQ-030 Response data: read hit -> mem_rdata; write or miss -> 0; err=1 only for miss.
REQ-031 rdata of the non-responding port SHALL be 0; response owner SHALL be registered, not recomputed.
REQ-032 Back-to-back accepts from alternating owners SHALL each yield correct rvalid on the correct port in consecutive cycles.
REQ-033 With no grant, mem_en, mem_we SHALL be 0; mem_addr/wdata/func3 SHALL be 0.

Reset
REQ-034 Asserted resetn SHALL force state IDLE, hold counter 0, all rvalid/err 0, response owner none, independent of clk.
REQ-035 Accepted request pending when reset asserts SHALL be dropped; no rvalid after release.
REQ-036 First cycle after release SHALL arbitrate normally.

Structure
REQ-037 Shared package data_mem_arb_pkg SHALL hold state enum, window base 0x800, window mask constants.
REQ-038 Window decode SHALL be sub-module dmem_addr_decode (addr in, hit out), instantiated once on granted address.

Verification
REQ-039 Core read 0x808 alone, mem_rdata=0x1122334455667788 -> core_ready same cycle, core_rvalid next cycle, core_rdata=0x1122334455667788, core_err=0.
REQ-040 Both req continuous, MAX_HOLD=8 -> 8 core grants, 1 debug grant, repeating; counter resets each debug grant.
REQ-041 Debug write addr 0x1000 -> mem_en=0, dbg_rvalid next cycle, dbg_err=1, dbg_rdata=0.
REQ-042 Core write 0x800 then debug read 0x800 consecutive cycles -> mem_we pulse then mem_en read; core_rvalid then dbg_rvalid on consecutive cycles.
REQ-043 resetn low the cycle after core accept -> core_rvalid never asserts; outputs 0; state IDLE.
REQ-044 Address 0x7FF and 0x0 -> err=1, no mem_en; 0xFFF -> hit, mem_addr=0x7FF.
